// File: rtl/krnl_rtl_trial_a_pkg.sv
// Shared types and helpers for the trial-A multi-source stream kernel.
package krnl_rtl_trial_a_pkg;

   typedef enum logic {ST_IDLE, ST_XFER} sched_state_t;

   localparam int LP_PKT_CNT_WIDTH = 32;

   // Index width that never collapses to zero bits, even for a single entry.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/krnl_rtl_trial_a_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module krnl_rtl_trial_a_rr_pick
   import krnl_rtl_trial_a_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = clog2_min1(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx
);

   logic [N-1:0] rot;
   logic [W-1:0] off;
   logic [W:0]   sum;

   // Rotating the doubled request vector puts the ptr position at bit 0.
   assign rot = N'({req, req} >> ptr);
   assign any = |req;

   // NOTE: off gets its default before the loop so no latch is inferred;
   // blocking assignments are the right choice inside combinational logic.
   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = W'(i);
      end
   end

   assign sum = {1'b0, ptr} + {1'b0, off};
   assign idx = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : sum[W-1:0];

endmodule

// File: rtl/krnl_rtl_trial_a_stream_sched.sv
// Packet-granular round-robin scheduler sharing one vadd AXIS datapath among C_NUM_SRC streams.
module krnl_rtl_trial_a_stream_sched
   import krnl_rtl_trial_a_pkg::*;
#(
   parameter  int                       C_NUM_SRC     = 4,
   parameter  int                       C_TDATA_WIDTH = 64,
   parameter  int                       C_CONST_WIDTH = 32,
   parameter  logic [C_CONST_WIDTH-1:0] C_CONST_RESET = 'd1,
   localparam int                       LP_IDX_W      = clog2_min1(C_NUM_SRC),
   localparam int                       LP_KEEP_W     = C_TDATA_WIDTH / 8
) (
   input  logic                                    ap_clk,
   input  logic                                    ap_rst_n,
   input  logic [C_NUM_SRC-1:0]                    s_axis_tvalid,
   output logic [C_NUM_SRC-1:0]                    s_axis_tready,
   input  logic [C_NUM_SRC*C_TDATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_NUM_SRC*LP_KEEP_W-1:0]          s_axis_tkeep,
   input  logic [C_NUM_SRC-1:0]                    s_axis_tlast,
   output logic                                    m_axis_tvalid,
   input  logic                                    m_axis_tready,
   output logic [C_TDATA_WIDTH-1:0]                m_axis_tdata,
   output logic [LP_KEEP_W-1:0]                    m_axis_tkeep,
   output logic                                    m_axis_tlast,
   output logic [C_CONST_WIDTH-1:0]                ctrl_constant,
   output logic [LP_IDX_W-1:0]                     grant_idx,
   output logic                                    busy,
   input  logic                                    cfg_wr_en,
   input  logic [LP_IDX_W-1:0]                     cfg_wr_idx,
   input  logic [C_CONST_WIDTH-1:0]                cfg_wr_data,
   output logic [C_NUM_SRC*LP_PKT_CNT_WIDTH-1:0]   pkt_count
);

   sched_state_t                                   state_q;
   logic [LP_IDX_W-1:0]                            grant_q;
   logic [LP_IDX_W-1:0]                            rr_ptr_q;
   logic [C_CONST_WIDTH-1:0]                       const_q;
   logic [C_NUM_SRC-1:0][C_CONST_WIDTH-1:0]        table_q;
   logic [C_NUM_SRC-1:0][LP_PKT_CNT_WIDTH-1:0]     pkt_cnt_q;
   logic                                           pick_any;
   logic [LP_IDX_W-1:0]                            pick_idx;
   logic                                           xfer;
   logic                                           last_hs;

   krnl_rtl_trial_a_rr_pick #(.N(C_NUM_SRC)) u_pick (
      .req (s_axis_tvalid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Pure pass-through of the granted source while a packet is in flight.
   assign xfer          = (state_q == ST_XFER);
   assign m_axis_tvalid = xfer & s_axis_tvalid[grant_q];
   assign m_axis_tdata  = s_axis_tdata[grant_q*C_TDATA_WIDTH +: C_TDATA_WIDTH];
   assign m_axis_tkeep  = s_axis_tkeep[grant_q*LP_KEEP_W +: LP_KEEP_W];
   assign m_axis_tlast  = s_axis_tlast[grant_q];
   assign s_axis_tready = xfer ? (C_NUM_SRC'(m_axis_tready) << grant_q) : '0;
   assign last_hs       = m_axis_tvalid & m_axis_tready & s_axis_tlast[grant_q];

   assign busy          = xfer;
   assign grant_idx     = grant_q;
   assign ctrl_constant = const_q;
   assign pkt_count     = pkt_cnt_q;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, e.g. const_q picks up the old table entry.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         const_q  <= C_CONST_RESET;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  state_q <= ST_XFER;
                  grant_q <= pick_idx;
                  const_q <= table_q[pick_idx];
               end
            end
            ST_XFER: begin
               if (last_hs) begin
                  state_q  <= ST_IDLE;
                  rr_ptr_q <= (grant_q == LP_IDX_W'(C_NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // NOTE: the constant table is a small register array with a defined reset
   // value, so it is reset like any other state rather than left uninitialised.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         table_q <= {C_NUM_SRC{C_CONST_RESET}};
      end else if (cfg_wr_en && (int'(cfg_wr_idx) < C_NUM_SRC)) begin
         table_q[cfg_wr_idx] <= cfg_wr_data;
      end
   end

   // Completed-packet counters wrap naturally at 2^32.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         pkt_cnt_q <= '0;
      end else if (last_hs) begin
         pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 1'b1;
      end
   end

endmodule

// File: tb/tb_krnl_rtl_trial_a_stream_sched.sv
// Directed self-checking bench for the round-robin stream scheduler.
module tb_krnl_rtl_trial_a_stream_sched;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int CW = 32;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n;
   logic [N-1:0]    s_axis_tvalid;
   logic [N-1:0]    s_axis_tready;
   logic [N*DW-1:0] s_axis_tdata;
   logic [N*KW-1:0] s_axis_tkeep;
   logic [N-1:0]    s_axis_tlast;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tlast;
   logic [CW-1:0]   ctrl_constant;
   logic [1:0]      grant_idx;
   logic            busy;
   logic            cfg_wr_en;
   logic [1:0]      cfg_wr_idx;
   logic [CW-1:0]   cfg_wr_data;
   logic [N*32-1:0] pkt_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 ap_clk = ~ap_clk;

   krnl_rtl_trial_a_stream_sched #(
      .C_NUM_SRC     (N),
      .C_TDATA_WIDTH (DW),
      .C_CONST_WIDTH (CW),
      .C_CONST_RESET (32'd1)
   ) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .ctrl_constant (ctrl_constant),
      .grant_idx     (grant_idx),
      .busy          (busy),
      .cfg_wr_en     (cfg_wr_en),
      .cfg_wr_idx    (cfg_wr_idx),
      .cfg_wr_data   (cfg_wr_data),
      .pkt_count     (pkt_count)
   );

   task automatic set_src(input int s, input logic v, input logic [DW-1:0] d,
                          input logic [KW-1:0] k, input logic l);
      s_axis_tvalid[s]       = v;
      s_axis_tdata[s*DW +: DW] = d;
      s_axis_tkeep[s*KW +: KW] = k;
      s_axis_tlast[s]        = l;
   endtask

   task automatic clear_inputs();
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = '0;
      m_axis_tready = 1'b1;
      cfg_wr_en     = 1'b0;
      cfg_wr_idx    = '0;
      cfg_wr_data   = '0;
   endtask

   // Leaves the caller at a falling edge with reset released and inputs idle.
   task automatic apply_reset();
      @(negedge ap_clk);
      clear_inputs();
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      ap_rst_n      = 1'b0;
      s_axis_tvalid = '1;
      for (int c = 0; c < 2; c++) begin
         @(negedge ap_clk);
         #1;
         n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready got=%b exp=0000", s_axis_tready); end
         n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid got=%b exp=0", m_axis_tvalid); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
         n_checks++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
         n_checks++; if (ctrl_constant !== 32'd1) begin n_fail++; $display("FAIL reset_const got=%0h exp=1", ctrl_constant); end
         n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL reset_pkt_count got=%0h exp=0", pkt_count); end
      end
      clear_inputs();
      ap_rst_n = 1'b1;
   endtask

   task automatic test_single_source();
      apply_reset();
      set_src(0, 1'b1, 64'hA0, 8'hFF, 1'b0);
      #1;
      n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle_mvalid got=%b exp=0", m_axis_tvalid); end
      n_checks++; if (s_axis_tready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_tready got=%b exp=0000", s_axis_tready); end
      @(negedge ap_clk);
      #1;
      n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin n_fail++; $display("FAIL single_grant got=%b/%0d exp=1/0", busy, grant_idx); end
      n_checks++; if (ctrl_constant !== 32'd1) begin n_fail++; $display("FAIL single_const got=%0h exp=1", ctrl_constant); end
      n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hA0) begin n_fail++; $display("FAIL single_beat0 got=%b/%0h exp=1/a0", m_axis_tvalid, m_axis_tdata); end
      n_checks++; if (s_axis_tready !== 4'b0001) begin n_fail++; $display("FAIL single_tready got=%b exp=0001", s_axis_tready); end
      @(negedge ap_clk);
      set_src(0, 1'b1, 64'hA1, 8'hFF, 1'b0);
      #1;
      n_checks++; if (m_axis_tdata !== 64'hA1 || m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL single_beat1 got=%0h/%b exp=a1/0", m_axis_tdata, m_axis_tlast); end
      @(negedge ap_clk);
      set_src(0, 1'b1, 64'hA2, 8'h0F, 1'b1);
      #1;
      n_checks++; if (m_axis_tdata !== 64'hA2 || m_axis_tkeep !== 8'h0F || m_axis_tlast !== 1'b1) begin
         n_fail++; $display("FAIL single_beat2 got=%0h/%0h/%b exp=a2/0f/1", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
      end
      @(negedge ap_clk);
      set_src(0, 1'b0, 64'h0, 8'h0, 1'b0);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy got=%b exp=0", busy); end
      n_checks++; if (pkt_count[0 +: 32] !== 32'd1) begin n_fail++; $display("FAIL single_pkt_count got=%0d exp=1", pkt_count[0 +: 32]); end
   endtask

   task automatic test_back_to_back();
      int   beat[N];
      int   grants[$];
      int   exp_order[5];
      int   idle_run;
      int   done;
      logic prev_busy;
      exp_order = '{0, 1, 2, 3, 0};
      beat      = '{0, 0, 0, 0};
      idle_run  = 0;
      done      = 0;
      prev_busy = 1'b0;
      apply_reset();
      for (int cyc = 0; cyc < 60 && done < 5; cyc++) begin
         for (int s = 0; s < N; s++) set_src(s, 1'b1, 64'(s * 16 + beat[s]), 8'hFF, beat[s] == 1);
         #1;
         if (busy) begin
            if (!prev_busy) begin
               grants.push_back(int'(grant_idx));
               n_checks++; if (idle_run != 1) begin n_fail++; $display("FAIL b2b_bubble pkt=%0d got=%0d exp=1", grants.size() - 1, idle_run); end
            end
            idle_run = 0;
         end else begin
            idle_run++;
         end
         if (m_axis_tvalid) begin
            n_checks++; if (m_axis_tdata !== 64'(int'(grant_idx) * 16 + beat[grant_idx])) begin
               n_fail++; $display("FAIL b2b_data src=%0d got=%0h exp=%0h", grant_idx, m_axis_tdata, int'(grant_idx) * 16 + beat[grant_idx]);
            end
         end
         if (m_axis_tvalid && m_axis_tready && m_axis_tlast) done++;
         for (int s = 0; s < N; s++) if (s_axis_tready[s] && s_axis_tvalid[s]) beat[s] ^= 1;
         prev_busy = busy;
         @(negedge ap_clk);
      end
      n_checks++; if (done != 5) begin n_fail++; $display("FAIL b2b_timeout got=%0d exp=5 packets", done); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (i >= grants.size()) begin n_fail++; $display("FAIL b2b_order idx=%0d got=none exp=%0d", i, exp_order[i]); end
         else if (grants[i] != exp_order[i]) begin n_fail++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, grants[i], exp_order[i]); end
      end
      clear_inputs();
      #1;
      n_checks++; if (pkt_count !== {32'd1, 32'd1, 32'd1, 32'd2}) begin n_fail++; $display("FAIL b2b_pkt_count got=%0h exp=1_1_1_2", pkt_count); end
   endtask

   task automatic test_cfg_write();
      apply_reset();
      set_src(2, 1'b1, 64'hC0, 8'hFF, 1'b0);
      @(negedge ap_clk);
      #1;
      n_checks++; if (grant_idx !== 2'd2 || ctrl_constant !== 32'd1) begin n_fail++; $display("FAIL cfg_grant got=%0d/%0h exp=2/1", grant_idx, ctrl_constant); end
      @(negedge ap_clk);
      set_src(2, 1'b1, 64'hC1, 8'hFF, 1'b0);
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd2; cfg_wr_data = 32'd7;
      #1;
      n_checks++; if (ctrl_constant !== 32'd1) begin n_fail++; $display("FAIL cfg_mid_const got=%0h exp=1", ctrl_constant); end
      @(negedge ap_clk);
      cfg_wr_en = 1'b0;
      set_src(2, 1'b1, 64'hC2, 8'hFF, 1'b1);
      #1;
      n_checks++; if (ctrl_constant !== 32'd1) begin n_fail++; $display("FAIL cfg_hold_const got=%0h exp=1", ctrl_constant); end
      @(negedge ap_clk);
      set_src(2, 1'b1, 64'hD0, 8'hFF, 1'b1);
      cfg_wr_en = 1'b1; cfg_wr_idx = 2'd2; cfg_wr_data = 32'd9;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cfg_bubble got=%b exp=0", busy); end
      @(negedge ap_clk);
      cfg_wr_en = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b1 || ctrl_constant !== 32'd7) begin n_fail++; $display("FAIL cfg_next_const got=%b/%0h exp=1/7", busy, ctrl_constant); end
      @(negedge ap_clk);
      set_src(2, 1'b1, 64'hE0, 8'hFF, 1'b1);
      @(negedge ap_clk);
      #1;
      n_checks++; if (ctrl_constant !== 32'd9) begin n_fail++; $display("FAIL cfg_collide_const got=%0h exp=9", ctrl_constant); end
      @(negedge ap_clk);
      clear_inputs();
   endtask

   task automatic test_ready_toggle();
      logic [DW-1:0] got[$];
      logic          pat[4];
      int            b;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1};
      b   = 0;
      apply_reset();
      set_src(1, 1'b1, 64'hB0, 8'hFF, 1'b0);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge ap_clk);
         set_src(0, 1'b1, 64'hDEAD, 8'hFF, 1'b1);
         set_src(3, 1'b1, 64'hBEEF, 8'hFF, 1'b1);
         set_src(1, 1'b1, 64'hB0 + 64'(b), 8'hFF, b == 2);
         m_axis_tready = pat[i];
         #1;
         n_checks++; if (s_axis_tready !== (pat[i] ? 4'b0010 : 4'b0000)) begin
            n_fail++; $display("FAIL toggle_tready cyc=%0d got=%b exp=%b", i, s_axis_tready, pat[i] ? 4'b0010 : 4'b0000);
         end
         n_checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hB0 + 64'(b)) begin
            n_fail++; $display("FAIL toggle_data cyc=%0d got=%b/%0h exp=1/%0h", i, m_axis_tvalid, m_axis_tdata, 64'hB0 + 64'(b));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            got.push_back(m_axis_tdata);
            b++;
         end
      end
      @(negedge ap_clk);
      clear_inputs();
      #1;
      n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL toggle_count got=%0d exp=3", got.size()); end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         n_checks++; if (got[i] !== 64'hB0 + 64'(i)) begin n_fail++; $display("FAIL toggle_beat idx=%0d got=%0h exp=%0h", i, got[i], 64'hB0 + 64'(i)); end
      end
      n_checks++; if (busy !== 1'b0 || pkt_count[32 +: 32] !== 32'd1) begin
         n_fail++; $display("FAIL toggle_done got=%b/%0d exp=0/1", busy, pkt_count[32 +: 32]);
      end
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      set_src(1, 1'b1, 64'h10, 8'hFF, 1'b0);
      @(negedge ap_clk);
      #1;
      n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd1) begin n_fail++; $display("FAIL rstmid_grant got=%b/%0d exp=1/1", busy, grant_idx); end
      @(negedge ap_clk);
      set_src(1, 1'b1, 64'h11, 8'hFF, 1'b0);
      set_src(0, 1'b1, 64'h20, 8'hFF, 1'b1);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1;
      n_checks++; if (s_axis_tready !== 4'b0000 || m_axis_tvalid !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_outputs got=%b/%b exp=0000/0", s_axis_tready, m_axis_tvalid);
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      @(negedge ap_clk);
      #1;
      n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd0 || s_axis_tready !== 4'b0001) begin
         n_fail++; $display("FAIL rstmid_rearb got=%b/%0d/%b exp=1/0/0001", busy, grant_idx, s_axis_tready);
      end
      @(negedge ap_clk);
      clear_inputs();
      #1;
      n_checks++; if (pkt_count !== {32'd0, 32'd0, 32'd0, 32'd1}) begin n_fail++; $display("FAIL rstmid_pkt_count got=%0h exp=0_0_0_1", pkt_count); end
   endtask

   task automatic test_counter_wrap();
      apply_reset();
      force dut.pkt_cnt_q = {32'hFFFF_FFFF, 96'd0};
      #1;
      release dut.pkt_cnt_q;
      #1;
      n_checks++; if (pkt_count !== {32'hFFFF_FFFF, 96'd0}) begin n_fail++; $display("FAIL wrap_preload got=%0h exp=ffffffff_0_0_0", pkt_count); end
      set_src(3, 1'b1, 64'h33, 8'hFF, 1'b1);
      @(negedge ap_clk);
      #1;
      n_checks++; if (busy !== 1'b1 || grant_idx !== 2'd3 || m_axis_tlast !== 1'b1) begin
         n_fail++; $display("FAIL wrap_grant got=%b/%0d/%b exp=1/3/1", busy, grant_idx, m_axis_tlast);
      end
      @(negedge ap_clk);
      set_src(3, 1'b0, 64'h0, 8'h0, 1'b0);
      set_src(0, 1'b1, 64'h44, 8'hFF, 1'b1);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle got=%b exp=0", busy); end
      n_checks++; if (pkt_count !== '0) begin n_fail++; $display("FAIL wrap_pkt_count got=%0h exp=0", pkt_count); end
      @(negedge ap_clk);
      #1;
      n_checks++; if (grant_idx !== 2'd0 || ctrl_constant !== 32'd1) begin
         n_fail++; $display("FAIL wrap_ptr got=%0d/%0h exp=0/1", grant_idx, ctrl_constant);
      end
      @(negedge ap_clk);
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_source();
      test_back_to_back();
      test_cfg_write();
      test_ready_toggle();
      test_reset_mid_packet();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
